// File: rtl/pulse_emit_scheduler_if.sv
// Channel-side and LED-side signals of the pulse emit scheduler.
// The bench drives the master side and the scheduler owns the slave side.
interface pulse_emit_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) ();
    localparam int PTR_W = $clog2(N_CH);

    logic                    en;
    logic [N_CH-1:0]         pulse_in;
    logic                    clr_ovf;
    logic                    led;
    logic [PTR_W-1:0]        active_ch;
    logic                    busy;
    logic [N_CH*CNT_W-1:0]   pending;
    logic [N_CH-1:0]         ovf;

    modport master (
        output en, pulse_in, clr_ovf,
        input  led, active_ch, busy, pending, ovf
    );

    modport slave (
        input  en, pulse_in, clr_ovf,
        output led, active_ch, busy, pending, ovf
    );
endinterface

// File: rtl/pulse_emit_scheduler.sv
// Queues 1-cycle pulses per channel and replays them round-robin on one LED
// as a DELAY / ON / GAP sequence.
//
// state | meaning
// IDLE  | waiting for en and a nonzero pending counter
// DELAY | granted, LED still dark for DELAY_CYC cycles
// ON    | LED lit for ON_CYC cycles
// GAP   | LED dark for GAP_CYC cycles before the next grant
module pulse_emit_scheduler #(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 8,
    parameter int unsigned DELAY_CYC = 100_000_000,
    parameter int unsigned ON_CYC    = 100_000_000,
    parameter int unsigned GAP_CYC   = 50_000_000
) (
    input logic                   clk,
    input logic                   reset,
    pulse_emit_scheduler_if.slave bus
);
    localparam int               PTR_W    = $clog2(N_CH);
    localparam logic [31:0]      DELAY_LD = 32'(DELAY_CYC - 1);
    localparam logic [31:0]      ON_LD    = 32'(ON_CYC - 1);
    localparam logic [31:0]      GAP_LD   = 32'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (N_CH < 2 || N_CH > 8) begin : g_bad_n_ch
        $error("pulse_emit_scheduler: N_CH must be 2..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pulse_emit_scheduler: CNT_W must be >= 1");
    end
    if (DELAY_CYC == 0 || ON_CYC == 0 || GAP_CYC == 0) begin : g_bad_cyc
        $error("pulse_emit_scheduler: DELAY_CYC, ON_CYC and GAP_CYC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, DELAY, ON, GAP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic             grant;
    logic [PTR_W-1:0] grant_ch;

    // Walk the search order backwards so the channel closest to rr_q wins.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = 1'b0;
        grant_ch = '0;
        if (state_q == IDLE && bus.en) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = (int'(rr_q) + k) % N_CH;
                if (cnt_q[idx] != '0) begin
                    grant    = 1'b1;
                    grant_ch = PTR_W'(idx);
                end
            end
        end
    end

    // A pulse coinciding with its own channel's grant cancels out, so it never overflows.
    always_comb begin
        ovf_d = ovf_q & ~{N_CH{bus.clr_ovf}};
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.pulse_in[i] && !(grant && grant_ch == PTR_W'(i))) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!bus.pulse_in[i] && grant && grant_ch == PTR_W'(i)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            rr_q    <= '0;
            act_q   <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rr_q    <= rr_d;
            act_q   <= act_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Timer is loaded with phase length minus one and the phase ends at zero.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rr_d    = rr_q;
        act_d   = act_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    act_d   = grant_ch;
                    rr_d    = (grant_ch == PTR_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
                    timer_d = DELAY_LD;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (timer_q == '0) begin
                    timer_d = ON_LD;
                    state_d = ON;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ON: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LD;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.led       = (state_q == ON);
        bus.busy      = (state_q != IDLE);
        bus.active_ch = act_q;
        bus.ovf       = ovf_q;
        bus.pending   = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.pending[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
endmodule

// File: tb/tb_pulse_emit_scheduler.sv
// Directed scenarios for pulse_emit_scheduler, checked every cycle against a
// grant-time model of the emission schedule plus hand-computed literals.
module tb_pulse_emit_scheduler;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int D  = 3;
    localparam int O  = 2;
    localparam int G  = 1;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pulse_emit_scheduler_if #(.N_CH(N), .CNT_W(CW)) bus ();

    pulse_emit_scheduler #(
        .N_CH(N), .CNT_W(CW), .DELAY_CYC(D), .ON_CYC(O), .GAP_CYC(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: an emission granted in cycle g is busy over g+1 .. g+D+O+G and lit
    // over g+1+D .. g+D+O; the next grant is possible from g+D+O+G+1 onward.
    int         cyc;
    int         m_g;
    int         m_end;
    int         m_act;
    int         m_rr;
    int         m_pend [N];
    logic [N-1:0] m_ovf;

    always @(posedge clk or negedge reset) begin : model
        logic         gnt;
        int           gch;
        logic [N-1:0] set;
        if (!reset) begin
            cyc   <= 0;
            m_g   <= -100;
            m_end <= 0;
            m_act <= 0;
            m_rr  <= 0;
            m_ovf <= '0;
            for (int i = 0; i < N; i++) m_pend[i] <= 0;
        end else begin
            gnt = 1'b0;
            gch = 0;
            if (cyc >= m_end && bus.en) begin
                for (int k = 0; k < N; k++) begin
                    if (!gnt && m_pend[(m_rr + k) % N] != 0) begin
                        gnt = 1'b1;
                        gch = (m_rr + k) % N;
                    end
                end
            end
            set = '0;
            for (int i = 0; i < N; i++) begin
                if (bus.pulse_in[i] && !(gnt && gch == i)) begin
                    if (m_pend[i] == SAT) set[i] = 1'b1;
                    else m_pend[i] <= m_pend[i] + 1;
                end else if (!bus.pulse_in[i] && gnt && gch == i) begin
                    m_pend[i] <= m_pend[i] - 1;
                end
            end
            m_ovf <= (bus.clr_ovf ? '0 : m_ovf) | set;
            if (gnt) begin
                m_g   <= cyc;
                m_end <= cyc + D + O + G + 1;
                m_act <= gch;
                m_rr  <= (gch + 1) % N;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input logic e, input logic [N-1:0] p, input logic c);
        int         exp_led;
        int         exp_busy;
        logic [N*CW-1:0] exp_pend;
        @(posedge clk);
        #1;
        bus.en       = e;
        bus.pulse_in = p;
        bus.clr_ovf  = c;
        @(negedge clk);
        exp_led  = (cyc >= m_g + 1 + D && cyc <= m_g + D + O) ? 1 : 0;
        exp_busy = (cyc > m_g && cyc < m_end) ? 1 : 0;
        for (int i = 0; i < N; i++) exp_pend[i*CW +: CW] = m_pend[i][CW-1:0];
        check("led", int'(bus.led), exp_led);
        check("busy", int'(bus.busy), exp_busy);
        check("active_ch", int'(bus.active_ch), m_act);
        check("pending", int'(bus.pending), int'(exp_pend));
        check("ovf", int'(bus.ovf), int'(m_ovf));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.en       = 1'b0;
        bus.pulse_in = '0;
        bus.clr_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int   emits;
        logic prev_busy;
        bus.en       = 1'b0;
        bus.pulse_in = '0;
        bus.clr_ovf  = 1'b0;

        // T1: single pulse on ch2 at cycle 10
        do_reset();
        check("rst_led", int'(bus.led), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_active", int'(bus.active_ch), 0);
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, (n == 10) ? 4'b0100 : 4'b0000, 1'b0);
            case (n)
                11: begin check("t1_busy11", int'(bus.busy), 0); check("t1_pend11", int'(bus.pending), 16); end
                12: begin check("t1_act12", int'(bus.active_ch), 2); check("t1_busy12", int'(bus.busy), 1); end
                14: check("t1_led14", int'(bus.led), 0);
                15: check("t1_led15", int'(bus.led), 1);
                16: check("t1_led16", int'(bus.led), 1);
                17: begin check("t1_led17", int'(bus.led), 0); check("t1_busy17", int'(bus.busy), 1); end
                18: check("t1_busy18", int'(bus.busy), 0);
                default: ;
            endcase
        end

        // T2: ch0, ch1, ch3 together at cycle 5; grants at 6, 13, 20
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            step(1'b1, (n == 5) ? 4'b1011 : 4'b0000, 1'b0);
            case (n)
                6:  check("t2_pend6", int'(bus.pending), 69);
                7:  begin check("t2_act7", int'(bus.active_ch), 0); check("t2_pend7", int'(bus.pending), 68); end
                9:  check("t2_led9", int'(bus.led), 0);
                10: check("t2_led10", int'(bus.led), 1);
                14: check("t2_act14", int'(bus.active_ch), 1);
                16: check("t2_led16", int'(bus.led), 0);
                17: check("t2_led17", int'(bus.led), 1);
                21: check("t2_act21", int'(bus.active_ch), 3);
                23: check("t2_led23", int'(bus.led), 0);
                24: check("t2_led24", int'(bus.led), 1);
                default: ;
            endcase
        end

        // T3: ch1 saturates during a ch0 emission; set beats clear at cycle 8
        do_reset();
        emits     = 0;
        prev_busy = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            step(1'b1, (n == 2) ? 4'b0001 : ((n >= 4 && n <= 8) ? 4'b0010 : 4'b0000),
                 (n == 8 || n == 40));
            if (bus.busy && !prev_busy && bus.active_ch == 2'd1) emits++;
            prev_busy = bus.busy;
            case (n)
                7:  check("t3_pend7", int'(bus.pending), 12);
                8:  check("t3_ovf8", int'(bus.ovf), 2);
                9:  begin check("t3_ovf9", int'(bus.ovf), 2); check("t3_pend9", int'(bus.pending), 12); end
                11: check("t3_pend11", int'(bus.pending), 8);
                33: begin check("t3_pend33", int'(bus.pending), 0); check("t3_busy33", int'(bus.busy), 0); end
                40: check("t3_ovf40", int'(bus.ovf), 2);
                41: check("t3_ovf41", int'(bus.ovf), 0);
                default: ;
            endcase
        end
        check("t3_emits", emits, 3);

        // T4: ch0 pulse in the same cycle as its grant
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, (n == 2 || n == 3) ? 4'b0001 : 4'b0000, 1'b0);
            case (n)
                3:  check("t4_pend3", int'(bus.pending), 1);
                4:  begin check("t4_pend4", int'(bus.pending), 1); check("t4_busy4", int'(bus.busy), 1); end
                10: begin check("t4_busy10", int'(bus.busy), 0); check("t4_pend10", int'(bus.pending), 1); end
                11: begin check("t4_busy11", int'(bus.busy), 1); check("t4_pend11", int'(bus.pending), 0); end
                13: check("t4_led13", int'(bus.led), 0);
                14: check("t4_led14", int'(bus.led), 1);
                default: ;
            endcase
        end

        // T5: en low with two ch2 pulses queued; en high only for cycles 40-41
        do_reset();
        for (int n = 1; n <= 55; n++) begin
            step((n == 40 || n == 41), (n == 3 || n == 5) ? 4'b0100 : 4'b0000, 1'b0);
            case (n)
                6:  check("t5_pend6", int'(bus.pending), 32);
                39: begin check("t5_busy39", int'(bus.busy), 0); check("t5_led39", int'(bus.led), 0); end
                40: check("t5_busy40", int'(bus.busy), 0);
                41: begin check("t5_busy41", int'(bus.busy), 1); check("t5_pend41", int'(bus.pending), 16); end
                43: check("t5_led43", int'(bus.led), 0);
                44: check("t5_led44", int'(bus.led), 1);
                50: begin check("t5_busy50", int'(bus.busy), 0); check("t5_pend50", int'(bus.pending), 16); end
                default: ;
            endcase
        end

        // T6: reset asserted while the LED is on
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            step(1'b1, (n >= 2 && n <= 6) ? 4'b1000 : 4'b0000, 1'b0);
        end
        check("t6_led_on", int'(bus.led), 1);
        check("t6_ovf_pre", int'(bus.ovf), 8);
        check("t6_pend_pre", int'(bus.pending), 192);
        #1;
        reset = 1'b0;
        #1;
        check("t6_led_rst", int'(bus.led), 0);
        check("t6_busy_rst", int'(bus.busy), 0);
        check("t6_pend_rst", int'(bus.pending), 0);
        check("t6_ovf_rst", int'(bus.ovf), 0);
        check("t6_act_rst", int'(bus.active_ch), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step(1'b1, 4'b0000, 1'b0);
        end
        check("t6_busy_after", int'(bus.busy), 0);
        check("t6_pend_after", int'(bus.pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
